dmem_rw_ctrl: RTL and testbench
===============================

DMEM_RW_CTRL -- requirements
Module: dmem_rw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning RAM word-address width (2048 words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h10010000, meaning byte address mapped to RAM word 0.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  CPU request strobe, sampled only when busy=0.
REQ-006 SHALL have port wea  input  1  request type: 1=store, 0=load.
REQ-007 SHALL have port addr  input  32  CPU byte address.
REQ-008 SHALL have port in_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port rol  input  3  size/sign: [1:0] 00=word, 01=half, 10=byte, 11=word; [2]=1 zero-extend load (ignored on store).
REQ-010 SHALL have port busy  output  1  request in progress.
REQ-011 SHALL have port out_data  output  32  registered load result.
REQ-012 SHALL have port err  output  1  misaligned-access flag.
REQ-013 SHALL have ports ram_en, ram_we  output  1 each  RAM enable and write enable.
REQ-014 SHALL have port ram_addr  output  ADDR_W  RAM word index.
REQ-015 SHALL have port ram_wdata  output  32  RAM write word.
REQ-016 SHALL have port ram_rdata  input  32  RAM read word, valid the cycle after ram_en=1, ram_we=0.

Function
REQ-017 SHALL compute ram_addr = ((addr - BASE_ADDR) >> 2) truncated to ADDR_W bits (out-of-range wraps modulo depth), latched with all request fields on accepted start.
REQ-018 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored with no side effect.
REQ-019 SHALL use FSM states IDLE, RD, CAP, WR, ERR; busy=1 in every state except IDLE, asserted the cycle after start.
REQ-020 SHALL on load: IDLE->RD (ram_en=1, ram_we=0)->CAP (register out_data)->IDLE; busy high exactly 2 cycles, out_data valid when busy falls.
REQ-021 SHALL on word store: IDLE->WR (ram_en=1, ram_we=1, ram_wdata=in_data)->IDLE; busy high 1 cycle.
REQ-022 SHALL on half/byte store perform read-modify-write: IDLE->RD->CAP (merge lane into ram_rdata)->WR->IDLE; busy high 3 cycles; untouched bytes preserved.
REQ-023 SHALL use little-endian lanes: addr[1:0]=0 selects bits [7:0]; half lane addr[1]=0 selects [15:0].
REQ-024 SHALL sign-extend byte/half loads when rol[2]=0 and zero-extend when rol[2]=1.
REQ-025 SHALL treat word access with addr[1:0]!=0 or half with addr[0]=1 as misaligned: IDLE->ERR->IDLE, no RAM enable, out_data unchanged, err=1 from ERR until next accepted start.
REQ-026 SHALL drive ram_en=ram_we=0 in IDLE and ERR; ram_we SHALL be 1 only in WR.
REQ-027 SHALL clear err on every accepted start and hold out_data between loads.

Reset
REQ-028 SHALL on rst=1 at a clock edge enter IDLE: busy=0, err=0, out_data=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-029 SHALL on reset mid-operation abandon the request; no write SHALL occur in the cycle following the reset edge; start coincident with rst SHALL be ignored.

Structure
REQ-030 SHALL place state encoding, rol size/sign constants and BASE_ADDR default in shared package dmem_pkg.
REQ-031 SHALL implement lane extract/sign-extend/merge in one combinational sub-module dmem_lane_unit; FSM and registers stay in dmem_rw_ctrl.

Verification
REQ-032 SHALL cover: store word 32'hDEADBEEF at 32'h10010008 then lw same -> RAM word 2 written, busy 1 then 2 cycles, out_data=32'hDEADBEEF.
REQ-033 SHALL cover: sb 8'h80 at 32'h10010009 into DEADBEEF -> word 32'hDEAD80EF; lb -> 32'hFFFFFF80; lbu -> 32'h00000080.
REQ-034 SHALL cover: sh 16'h1234 at 32'h1001000A -> word 32'h123480EF; lh at 32'h1001000B -> err=1, no ram_en, out_data unchanged.
REQ-035 SHALL cover: start pulsed every cycle during a 3-cycle RMW -> only first request executes, exactly one write.
REQ-036 SHALL cover: rst asserted in CAP of an sb -> next cycle IDLE, ram_we never 1, RAM word unchanged, all outputs at reset values.
REQ-037 SHALL cover: lw at BASE_ADDR + 4*2048 -> ram_addr=0 (wrap).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory read/write controller:
// FSM state encoding, rol size/sign constants and the default RAM base address.
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_ERR
  } dmem_state_e;

  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b10;
  localparam logic [1:0] SZ_WORD3 = 2'b11;

  localparam int unsigned ROL_ZEXT_BIT = 2;

  localparam logic [31:0] DMEM_BASE_ADDR_DEF = 32'h1001_0000;

  function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_BYTE: return 1'b0;
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte/half lane handling: extracts and extends load data,
// and merges store data into the word read back from RAM.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rdata[7:0];
    half_sel   = off[1] ? rdata[31:16] : rdata[15:0];
    load_data  = rdata;
    merge_data = wdata;

    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase

    case (size)
      SZ_BYTE: begin
        load_data  = zext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merge_data = rdata;
        case (off)
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          2'd3:    merge_data[31:24] = wdata[7:0];
          default: merge_data[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        load_data  = zext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merge_data = off[1] ? {wdata[15:0], rdata[15:0]} : {rdata[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_rw_ctrl.sv
// Data-memory controller: sequences CPU loads, word stores and byte/half
// read-modify-write stores onto a single-port synchronous RAM.
module dmem_rw_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wea,
  input  logic [31:0]       addr,
  input  logic [31:0]       in_data,
  input  logic [2:0]        rol,
  output logic              busy,
  output logic [31:0]       out_data,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              err_q, err_d;
  logic              wea_q, wea_d;
  logic              zext_q, zext_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;

  logic [ADDR_W-1:0] req_idx;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              req_word;

  assign req_idx  = ADDR_W'((addr - BASE_ADDR) >> 2);
  assign req_word = (rol[1:0] == SZ_WORD) || (rol[1:0] == SZ_WORD3);

  dmem_lane_unit u_lane (
    .rdata      (ram_rdata),
    .wdata      (ram_wdata_q),
    .off        (off_q),
    .size       (size_q),
    .zext       (zext_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    wea_d       = wea_q;
    zext_d      = zext_q;
    off_d       = off_q;
    size_d      = size_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ram_addr_d = req_idx;
          wea_d      = wea;
          zext_d     = rol[ROL_ZEXT_BIT];
          off_d      = addr[1:0];
          size_d     = rol[1:0];
          err_d      = 1'b0;
          if (wea) begin
            ram_wdata_d = in_data;
          end
          if (dmem_misaligned(rol[1:0], addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else if (wea && req_word) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        // Store path reaches CAP only for sub-word stores: merge into the fetched word.
        if (wea_q) begin
          ram_wdata_d = merge_data;
          state_d     = ST_WR;
        end else begin
          out_data_d = load_data;
          state_d    = ST_IDLE;
        end
      end
      ST_WR:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      wea_q       <= 1'b0;
      zext_q      <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      wea_q       <= wea_d;
      zext_q      <= zext_d;
      off_q       <= off_d;
      size_q      <= size_d;
    end
  end

  always_comb begin
    busy   = state_q != ST_IDLE;
    ram_en = (state_q == ST_RD) || (state_q == ST_WR);
    ram_we = state_q == ST_WR;
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_rw_ctrl.sv
// Directed bench for dmem_rw_ctrl with a behavioural single-port RAM
// (one-cycle read latency) and hand-computed expected values.
module tb_dmem_rw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wea;
  logic [31:0] addr;
  logic [31:0] in_data;
  logic [2:0]  rol;
  logic        busy;
  logic [31:0] out_data;
  logic        err;
  logic        ram_en;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:2047] = '{default: '0};
  int          writes = 0;
  int          enables = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_rw_ctrl #(.ADDR_W(11), .BASE_ADDR(32'h1001_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .wea       (wea),
    .addr      (addr),
    .in_data   (in_data),
    .rol       (rol),
    .busy      (busy),
    .out_data  (out_data),
    .err       (err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) enables <= enables + 1;
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      writes        <= writes + 1;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] r, output int n, output logic [10:0] ra);
    @(negedge clk);
    start = 1'b1; wea = w; addr = a; in_data = d; rol = r;
    @(negedge clk);
    start = 1'b0;
    n  = 0;
    ra = ram_addr;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  int          n;
  logic [10:0] ra;
  int          w0, e0;

  initial begin
    rst = 1'b1; start = 1'b0; wea = 1'b0; addr = '0; in_data = '0; rol = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy),      32'h0);
    check("rst_err",    32'(err),       32'h0);
    check("rst_out",    out_data,       32'h0);
    check("rst_en",     32'(ram_en),    32'h0);
    check("rst_we",     32'(ram_we),    32'h0);
    check("rst_addr",   32'(ram_addr),  32'h0);
    check("rst_wdata",  ram_wdata,      32'h0);
    rst = 1'b0;

    // sw / lw at word 2
    w0 = writes;
    do_req(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 3'b000, n, ra);
    check("sw_busy",  32'(n),          32'd1);
    check("sw_addr",  32'(ra),         32'd2);
    check("sw_mem",   mem[2],          32'hDEAD_BEEF);
    check("sw_nwr",   32'(writes - w0), 32'd1);
    do_req(1'b0, 32'h1001_0008, 32'h0, 3'b000, n, ra);
    check("lw_busy",  32'(n),          32'd2);
    check("lw_out",   out_data,        32'hDEAD_BEEF);

    // byte store / loads
    do_req(1'b1, 32'h1001_0009, 32'h0000_0080, 3'b010, n, ra);
    check("sb_busy",  32'(n),          32'd3);
    check("sb_mem",   mem[2],          32'hDEAD_80EF);
    do_req(1'b0, 32'h1001_0009, 32'h0, 3'b010, n, ra);
    check("lb_out",   out_data,        32'hFFFF_FF80);
    do_req(1'b0, 32'h1001_0009, 32'h0, 3'b110, n, ra);
    check("lbu_out",  out_data,        32'h0000_0080);

    // half store, misaligned half load
    do_req(1'b1, 32'h1001_000A, 32'h0000_1234, 3'b001, n, ra);
    check("sh_mem",   mem[2],          32'h1234_80EF);
    e0 = enables;
    do_req(1'b0, 32'h1001_000B, 32'h0, 3'b001, n, ra);
    check("mis_busy", 32'(n),          32'd1);
    check("mis_err",  32'(err),        32'h1);
    check("mis_en",   32'(enables - e0), 32'd0);
    check("mis_out",  out_data,        32'h0000_0080);
    @(negedge clk);
    check("mis_hold", 32'(err),        32'h1);
    do_req(1'b0, 32'h1001_0008, 32'h0, 3'b001, n, ra);
    check("lh_err",   32'(err),        32'h0);
    check("lh_out",   out_data,        32'hFFFF_80EF);
    do_req(1'b0, 32'h1001_000A, 32'h0, 3'b101, n, ra);
    check("lhu_out",  out_data,        32'h0000_1234);

    // start held high throughout an RMW
    w0 = writes;
    @(negedge clk);
    start = 1'b1; wea = 1'b1; addr = 32'h1001_0008; in_data = 32'h11; rol = 3'b010;
    @(negedge clk);
    addr = 32'h1001_0014; in_data = 32'hFFFF_FFFF; rol = 3'b000;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("stk_busy", 32'(busy),       32'h0);
    check("stk_nwr",  32'(writes - w0), 32'd1);
    check("stk_mem2", mem[2],          32'h1234_8011);
    check("stk_mem5", mem[5],          32'h0);

    // reset during CAP of a byte store
    w0 = writes;
    @(negedge clk);
    start = 1'b1; wea = 1'b1; addr = 32'h1001_0008; in_data = 32'h55; rol = 3'b010;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rcap_busy",  32'(busy),     32'h0);
    check("rcap_we",    32'(ram_we),   32'h0);
    check("rcap_en",    32'(ram_en),   32'h0);
    check("rcap_out",   out_data,      32'h0);
    check("rcap_addr",  32'(ram_addr), 32'h0);
    check("rcap_wdata", ram_wdata,     32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rcap_nwr",   32'(writes - w0), 32'd0);
    check("rcap_mem",   mem[2],        32'h1234_8011);

    // start coincident with reset
    rst = 1'b1; start = 1'b1; wea = 1'b0; addr = 32'h1001_0008; rol = 3'b000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start", 32'(busy),      32'h0);

    // address wrap past RAM depth
    do_req(1'b1, 32'h1001_2000, 32'hA5A5_A5A5, 3'b000, n, ra);
    check("wrap_waddr", 32'(ra),       32'd0);
    check("wrap_mem",   mem[0],        32'hA5A5_A5A5);
    do_req(1'b0, 32'h1001_2000, 32'h0, 3'b000, n, ra);
    check("wrap_raddr", 32'(ra),       32'd0);
    check("wrap_out",   out_data,      32'hA5A5_A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
